// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan observer.
// Glyphs are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package seven_seg_scan_pkg;

  localparam logic [7:0] GLYPH_0 = 8'hC0;
  localparam logic [7:0] GLYPH_1 = 8'hF9;
  localparam logic [7:0] GLYPH_2 = 8'hA4;
  localparam logic [7:0] GLYPH_3 = 8'hB0;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h92;
  localparam logic [7:0] GLYPH_6 = 8'h82;
  localparam logic [7:0] GLYPH_7 = 8'hF8;
  localparam logic [7:0] GLYPH_8 = 8'h80;
  localparam logic [7:0] GLYPH_9 = 8'h90;

  // every segment dark (dp ignored by the decoder)
  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

  localparam logic [3:0] DIG_INVALID = 4'hF;
  localparam logic [3:0] DIG_BLANK   = 4'hA;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} cap_state_e;

  typedef enum logic [2:0] {
    SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_DP
  } seg_bit_e;

endpackage

// File: rtl/seg_glyph_lut.sv
// Seven-segment pattern to BCD decoder.
// Build option SEG_BLANK_EN: an all-dark pattern decodes to DIG_BLANK as a
// legal digit (blanked leading zeros); otherwise it is flagged illegal.
module seg_glyph_lut
  import seven_seg_scan_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] dig,
  output logic       illegal
);

  // match the pattern against the ten legal glyphs
  always_comb begin
    dig     = DIG_INVALID;
    illegal = 1'b1;
    case (pat)
      GLYPH_0[6:0]: begin dig = 4'd0; illegal = 1'b0; end
      GLYPH_1[6:0]: begin dig = 4'd1; illegal = 1'b0; end
      GLYPH_2[6:0]: begin dig = 4'd2; illegal = 1'b0; end
      GLYPH_3[6:0]: begin dig = 4'd3; illegal = 1'b0; end
      GLYPH_4[6:0]: begin dig = 4'd4; illegal = 1'b0; end
      GLYPH_5[6:0]: begin dig = 4'd5; illegal = 1'b0; end
      GLYPH_6[6:0]: begin dig = 4'd6; illegal = 1'b0; end
      GLYPH_7[6:0]: begin dig = 4'd7; illegal = 1'b0; end
      GLYPH_8[6:0]: begin dig = 4'd8; illegal = 1'b0; end
      GLYPH_9[6:0]: begin dig = 4'd9; illegal = 1'b0; end
`ifdef SEG_BLANK_EN
      SEG_ALL_OFF[6:0]: begin dig = DIG_BLANK; illegal = 1'b0; end
`else
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Observer for a multiplexed seven-segment display bus. Synchronises the
// pins, waits for SETTLE_CYC identical samples on a single active anode,
// decodes the digit and publishes a frame once every digit was captured.
// Build option SEG_BLANK_EN (see seg_glyph_lut) accepts blanked digits.
module seven_seg_scan_capture
  import seven_seg_scan_pkg::*;
#(
  parameter int NUM_DIG     = 6,
  parameter int SETTLE_CYC  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           seg_in,
  input  logic [NUM_DIG-1:0]   an_in,
  output logic [4*NUM_DIG-1:0] digits_out,
  output logic [NUM_DIG-1:0]   dp_out,
  output logic [NUM_DIG-1:0]   invalid_out,
  output logic                 frame_valid,
  output logic                 anode_err,
  output logic                 stalled
);

  localparam int             TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_MAX     = TW'(TIMEOUT_CYC);
  localparam logic [7:0]     SETTLE_TGT = 8'(SETTLE_CYC);

  logic [SYNC_STAGES-1:0][7:0]         seg_pipe;
  logic [SYNC_STAGES-1:0][NUM_DIG-1:0] an_pipe;
  logic [7:0]                          s_seg, prev_seg;
  logic [NUM_DIG-1:0]                  s_an, prev_an, an_lo;
  logic                                one_hot, multi_hot, changed;

  cap_state_e state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       cap;

  logic [3:0] lut_dig;
  logic       lut_ill;

  logic [NUM_DIG-1:0][3:0] sh_dig;
  logic [NUM_DIG-1:0]      sh_dp, sh_inv, mask, mask_nxt;
  logic                    pub_pend;
  logic [TW-1:0]           to_cnt;

  // input synchroniser; resets to the idle bus (all lines high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_pipe <= '1;
      an_pipe  <= '1;
    end else begin
      seg_pipe <= {seg_pipe[SYNC_STAGES-2:0], seg_in};
      an_pipe  <= {an_pipe[SYNC_STAGES-2:0], an_in};
    end
  end

  assign s_seg = seg_pipe[SYNC_STAGES-1];
  assign s_an  = an_pipe[SYNC_STAGES-1];

  // previous synchronised sample for stability detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg <= '1;
      prev_an  <= '1;
    end else begin
      prev_seg <= s_seg;
      prev_an  <= s_an;
    end
  end

  assign an_lo     = ~s_an;
  assign one_hot   = (an_lo != '0) && ((an_lo & (an_lo - NUM_DIG'(1))) == '0);
  assign multi_hot = (an_lo != '0) && !one_hot;
  assign changed   = (s_seg != prev_seg) || (s_an != prev_an);

  // settle FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // settle FSM: count identical samples, capture once when the target is hit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    if (!one_hot) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE:    begin state_nxt = SETTLE; cnt_nxt = 8'd1; end
        SETTLE:  cnt_nxt = changed ? 8'd1 : cnt + 8'd1;
        HOLD:    if (changed) begin state_nxt = SETTLE; cnt_nxt = 8'd1; end
        default: begin state_nxt = IDLE; cnt_nxt = '0; end
      endcase
      if (state_nxt == SETTLE && cnt_nxt == SETTLE_TGT) begin
        cap       = 1'b1;
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    end
  end

  seg_glyph_lut u_lut (
    .pat     (s_seg[6:0]),
    .dig     (lut_dig),
    .illegal (lut_ill)
  );

  // a publish clears the mask first so a same-cycle capture starts the next frame
  always_comb begin
    mask_nxt = pub_pend ? '0 : mask;
    if (cap) mask_nxt = mask_nxt | an_lo;
  end

  // shadow frame: capture writes the selected digit, later recaptures overwrite
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dig   <= '0;
      sh_dp    <= '0;
      sh_inv   <= '0;
      mask     <= '0;
      pub_pend <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (cap && an_lo[i]) begin
          sh_dig[i] <= lut_dig;
          sh_dp[i]  <= ~s_seg[SEG_DP];
          sh_inv[i] <= lut_ill;
        end
      end
      mask     <= mask_nxt;
      pub_pend <= cap && (&mask_nxt);
    end
  end

  // published frame, updated only one cycle after the completing capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_out  <= '0;
      dp_out      <= '0;
      invalid_out <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= pub_pend;
      if (pub_pend) begin
        digits_out  <= sh_dig;
        dp_out      <= sh_dp;
        invalid_out <= sh_inv;
      end
    end
  end

  // sticky flag for overlapping anodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) anode_err <= 1'b0;
    else if (multi_hot) anode_err <= 1'b1;
  end

  // saturating no-capture counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt <= '0;
    else if (cap) to_cnt <= '0;
    else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TW'(1);
  end

  assign stalled = (to_cnt >= TO_MAX);

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Bench for seven_seg_scan_capture: directed scans plus random bus traffic,
// every cycle compared against a run-length reference model of the bus.
module tb_seven_seg_scan_capture;

  localparam int ND = 6;
  localparam int SC = 4;
  localparam int SS = 2;
  localparam int TO = 64;

  typedef struct packed {
    logic [7:0]    seg;
    logic [ND-1:0] an;
  } smp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      seg_in = 8'hFF;
  logic [ND-1:0]   an_in = '1;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0]   dp_out, invalid_out;
  logic            frame_valid, anode_err, stalled;

  always #5 clk = ~clk;

  seven_seg_scan_capture #(
    .NUM_DIG(ND), .SETTLE_CYC(SC), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .dp_out(dp_out), .invalid_out(invalid_out),
    .frame_valid(frame_valid), .anode_err(anode_err), .stalled(stalled)
  );

  int checks = 0;
  int failures = 0;
  int fcnt = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  logic [7:0] gl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // ---------------- reference model ----------------
  smp_t                dq[$];
  smp_t                prv;
  int                  run;
  logic [ND-1:0][3:0]  m_sdig, m_dig;
  logic [ND-1:0]       m_sdp, m_sinv, m_mask, m_dp, m_inv;
  bit                  m_pend, m_fv, m_aerr;
  int                  m_to;

  function automatic void decode(input logic [7:0] s, output logic [3:0] d, output logic iv);
    d = 4'hF; iv = 1'b1;
    for (int k = 0; k < 10; k++)
      if (s[6:0] == gl[k][6:0]) begin d = 4'(k); iv = 1'b0; end
`ifdef SEG_BLANK_EN
    if (s[6:0] == 7'h7F) begin d = 4'hA; iv = 1'b0; end
`endif
  endfunction

  task automatic m_reset();
    smp_t idle;
    idle = '{seg: 8'hFF, an: '1};
    dq = {};
    for (int i = 0; i < SS; i++) dq.push_back(idle);
    prv = idle; run = 0;
    m_sdig = '0; m_dig = '0; m_sdp = '0; m_sinv = '0; m_mask = '0;
    m_dp = '0; m_inv = '0; m_pend = 0; m_fv = 0; m_aerr = 0; m_to = 0;
  endtask

  task automatic m_step();
    smp_t s, cur;
    logic [ND-1:0] lo;
    logic [3:0] d;
    logic iv;
    bit cap;
    cur = '{seg: seg_in, an: an_in};
    dq.push_back(cur);
    s = dq.pop_front();
    lo = ~s.an;
    if (s == prv) begin if (run < 1000) run++; end
    else run = 1;
    prv = s;
    cap = ($countones(lo) == 1) && (run == SC);
    if ($countones(lo) > 1) m_aerr = 1;
    if (m_pend) begin
      m_dig = m_sdig; m_dp = m_sdp; m_inv = m_sinv;
      m_mask = '0; m_fv = 1; m_pend = 0;
    end else m_fv = 0;
    if (cap) begin
      decode(s.seg, d, iv);
      for (int i = 0; i < ND; i++)
        if (lo[i]) begin
          m_sdig[i] = d; m_sdp[i] = ~s.seg[7]; m_sinv[i] = iv; m_mask[i] = 1'b1;
        end
      if (&m_mask) m_pend = 1;
      m_to = 0;
    end else if (m_to < TO) m_to++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("digits", digits_out, m_dig);
    chk("dp", dp_out, m_dp);
    chk("inv", invalid_out, m_inv);
    chk("fv", frame_valid, m_fv);
    chk("aerr", anode_err, m_aerr);
    chk("stall", stalled, m_to >= TO);
    if (frame_valid) fcnt++;
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic [7:0] s, input logic [ND-1:0] a, input int n);
    seg_in = s;
    an_in  = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [ND-1:0][7:0] segs, input int dwell, input int blank,
                      input int first, input int last);
    for (int d = first; d <= last; d++) begin
      drv(segs[d], ~(ND'(1) << d), dwell);
      if (blank > 0) drv(8'hFF, '1, blank);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_digits", digits_out, 0);
    chk("rst_flags", {dp_out, invalid_out, frame_valid, anode_err, stalled}, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ND-1:0][7:0] s123, segs;
    int fc0;
    s123 = {gl[6], gl[5], gl[4], gl[3], gl[2], gl[1]};

    // reset state and timeout from an idle bus
    #1;
    chk("rst0_digits", digits_out, 0);
    chk("rst0_flags", {dp_out, invalid_out, frame_valid, anode_err, stalled}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (63) @(posedge clk);
    #1 chk("stall_63", stalled, 0);
    @(posedge clk);
    #1 chk("stall_64", stalled, 1);
    @(negedge clk);

    // clean "123456" scan
    fc0 = fcnt;
    scan(s123, 8, 2, 0, ND-1);
    drv(8'hFF, '1, 8);
    #1;
    chk("f1_cnt", fcnt - fc0, 1);
    chk("f1_digits", digits_out, 24'h654321);
    chk("f1_inv", invalid_out, 0);
    chk("f1_dp", dp_out, 0);
    chk("f1_stall", stalled, 0);

    // digit 2 shows "5." with dp lit
    segs = s123; segs[2] = 8'h12;
    fc0 = fcnt;
    scan(segs, 8, 2, 0, ND-1);
    drv(8'hFF, '1, 8);
    #1;
    chk("f2_cnt", fcnt - fc0, 1);
    chk("f2_dp", dp_out, 6'b000100);
    chk("f2_dig2", digits_out[11:8], 5);

    // dwell shorter than the settle window never captures
    fc0 = fcnt;
    scan(s123, 3, 2, 0, ND-1);
    drv(8'hFF, '1, 8);
    #1 chk("short_cnt", fcnt - fc0, 0);

    // mid-dwell toggle on digit 0: the later glyph wins
    fc0 = fcnt;
    drv(gl[7], ~ND'(1), 6);
    drv(gl[8], ~ND'(1), 8);
    drv(8'hFF, '1, 2);
    scan(s123, 8, 2, 1, ND-1);
    drv(8'hFF, '1, 8);
    #1;
    chk("tog_cnt", fcnt - fc0, 1);
    chk("tog_dig0", digits_out[3:0], 8);

    // all-dark pattern on digit 5
    segs = s123; segs[5] = 8'hFF;
    scan(segs, 8, 2, 0, ND-1);
    drv(8'hFF, '1, 8);
    #1;
`ifdef SEG_BLANK_EN
    chk("blank_dig5", digits_out[23:20], 4'hA);
    chk("blank_inv5", invalid_out[5], 0);
`else
    chk("blank_dig5", digits_out[23:20], 4'hF);
    chk("blank_inv5", invalid_out[5], 1);
`endif

    // overlapping anodes: sticky error, no capture, later scan still publishes
    fc0 = fcnt;
    drv(gl[1], 6'b111100, 10);
    drv(8'hFF, '1, 4);
    #1;
    chk("aerr_set", anode_err, 1);
    chk("aerr_nocap", fcnt - fc0, 0);
    scan(s123, 8, 2, 0, ND-1);
    drv(8'hFF, '1, 8);
    #1;
    chk("aerr_frame", fcnt - fc0, 1);
    chk("aerr_hold", anode_err, 1);

    // reset after three captures discards the partial frame
    scan(s123, 8, 2, 0, 2);
    do_reset();
    @(negedge clk);
    fc0 = fcnt;
    scan(s123, 8, 2, 3, ND-1);
    drv(8'hFF, '1, 8);
    #1;
    chk("part_cnt", fcnt - fc0, 0);
    chk("part_digits", digits_out, 0);
    scan(s123, 8, 2, 0, ND-1);
    drv(8'hFF, '1, 8);
    #1;
    chk("post_rst_cnt", fcnt - fc0, 1);
    chk("post_rst_digits", digits_out, 24'h654321);

    // random traffic against the model
    for (int r = 0; r < 40; r++) begin
      for (int d = 0; d < ND; d++) begin
        logic [7:0] s;
        int k;
        k = $urandom_range(0, 99);
        if (k < 75) begin
          s = gl[$urandom_range(0, 9)];
          if ($urandom_range(0, 3) == 0) s[7] = 1'b0;
        end else if (k < 88) s = 8'($urandom);
        else s = 8'hFF;
        drv(s, ~(ND'(1) << d), $urandom_range(1, 9));
        if ($urandom_range(0, 4) == 0)
          drv(8'($urandom), ~(ND'(1) << d), $urandom_range(1, 6));
        if ($urandom_range(0, 29) == 0)
          drv(s, ND'($urandom), $urandom_range(1, 3));
        drv(8'hFF, '1, $urandom_range(0, 2));
      end
    end
    drv(8'hFF, '1, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_capture.md
Name: seven_seg_scan_capture

Overview:
- Observer for the multiplexed 6-digit display bus: takes the shared segment lines and the per-digit anode lines as driven to the board pins.
- Synchronises and settle-filters the bus, decodes each lit digit back to BCD and assembles full frames.
- Used in benches and on-chip self-check to confirm the timer/stopwatch display path end to end, from count registers through the encoder and scan mux.

Parameters:
- NUM_DIG, 6, number of multiplexed digits (anode width).
- SETTLE_CYC, 4, consecutive identical synchronised samples required before a capture; range 1..255.
- SYNC_STAGES, 2, flops in the input synchroniser; minimum 2.
- TIMEOUT_CYC, 1048576, cycles with no capture before the stalled flag asserts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_in  in  8  segment bus {dp,g,f,e,d,c,b,a}, active-low
- an_in  in  NUM_DIG  anode selects, active-low, bit 0 = rightmost digit
- digits_out  out  4*NUM_DIG  captured BCD frame, digit 0 in [3:0]
- dp_out  out  NUM_DIG  captured decimal points, 1 = lit
- invalid_out  out  NUM_DIG  1 = digit pattern not a legal 0-9 glyph
- frame_valid  out  1  one-cycle pulse when a new complete frame is published
- anode_err  out  1  sticky: more than one anode active seen after synchronisation
- stalled  out  1  no capture for TIMEOUT_CYC cycles

Behaviour:
- Reset: async on rst_n low.
  - digits_out = 0, dp_out = 0, invalid_out = 0, frame_valid = 0, anode_err = 0, stalled = 0.
  - Capture mask, shadow registers, settle counter and timeout counter cleared; FSM returns to IDLE.
- Synchroniser: seg_in and an_in pass through SYNC_STAGES flops; all later logic uses the synchronised copy (s_seg, s_an).
- Anode check: s_an must be one-hot low.
  - All high (blank interval) -> no capture.
  - More than one low -> no capture and anode_err set (sticky until reset).
- FSM states:
  - IDLE: s_an invalid. Goes to SETTLE when s_an becomes one-hot.
  - SETTLE: counter increments while {s_seg, s_an} equals the previous sample.
    - Any change while still one-hot -> counter reloads to 1 and FSM stays in SETTLE.
    - s_an no longer one-hot -> IDLE.
    - Counter reaches SETTLE_CYC -> capture on that edge, then HOLD.
  - HOLD: waits for any change in {s_seg, s_an}, then goes to SETTLE or IDLE as above. Exactly one capture per stable dwell.
  - Latency: pin change to capture = SYNC_STAGES + SETTLE_CYC cycles when held stable.
- Capture action (index i = position of the low bit in s_an):
  - Shadow digit[i] = decoded value (0-9, or 4'hF if the pattern is illegal).
  - Shadow dp[i] = ~s_seg[7]; shadow inv[i] = illegal flag; mask[i] set.
  - Decode ignores dp.
  - Legal glyphs (hex, dp off): 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90.
- Frame publish:
  - On the cycle after a capture that makes mask all ones, copy the shadow registers to digits_out/dp_out/invalid_out, pulse frame_valid high for 1 cycle and clear mask.
  - Outputs never change except at a publish.
  - Recapturing an already-set digit before the frame completes overwrites its shadow entry; the mask is unchanged.
- Timeout:
  - Counter clears on every capture; otherwise it saturates.
  - stalled = 1 while the counter is >= TIMEOUT_CYC, and drops the cycle after the next capture.
- Simultaneous events: a capture and a publish in the same cycle are impossible (publish is one cycle later). A capture in the publish cycle sets the new mask bit after the clear.
- Reset mid-frame discards the partial frame; there is no publish.

Optional Feature:
- SEG_BLANK_EN defined:
  - seg pattern FF or 7F (all segments off) decodes to 4'hA with inv = 0. A blanked leading-zero digit then counts as valid.
- SEG_BLANK_EN undefined: those patterns decode to 4'hF with inv = 1.

Decomposition:
- Package seven_seg_scan_pkg holds:
  - localparams for the ten glyph constants, DIG_INVALID = 4'hF and DIG_BLANK = 4'hA;
  - the FSM state enum {IDLE, SETTLE, HOLD};
  - a segment-bit index enum.
- Sub-module seg_glyph_lut: combinational, 7-bit pattern in, 4-bit digit and illegal flag out. Glyph matching lives there; the SEG_BLANK_EN switch sits in this module.

Test Plan:
- Scan digits 0-5 showing "123456" (F9,A4,B0,99,92,82), each anode held 8 cycles with a 2-cycle blank between -> one frame_valid, digits_out = 24'h654321, invalid_out = 0, dp_out = 0.
- Same scan but digit 2 driven 12 (dp lit on "5") -> dp_out = 6'b000100 and digits_out[11:8] = 5.
- Anode held only 3 cycles with SETTLE_CYC = 4 -> no capture, no frame_valid. Toggle seg once mid-dwell at 6 cycles -> capture at 4 cycles after the toggle.
- an_in = 6'b111100 for 10 cycles -> anode_err = 1 and stays set, no capture; a following clean scan still publishes a frame.
- seg = 8'hFF on digit 5 -> digit 4'hF with invalid_out[5] = 1 when SEG_BLANK_EN is undefined; digit 4'hA with invalid_out[5] = 0 when it is defined.
- TIMEOUT_CYC = 64 with no scan -> stalled at cycle 64. Assert rst_n low mid-frame after 3 captures -> all outputs 0, and the next full scan is needed to publish.
